// File: rtl/ifetch_prefetch.sv
// Fetch stage: owns the fetch PC, issues in-order imem reads and buffers returned words in a prefetch FIFO.
// Latency: a word returned L cycles after acceptance reaches instr_F L+1 cycles after acceptance.
// Backpressure: issue is credit-limited (inflight + buffered < DEPTH); stall_D holds the FIFO head.
module ifetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_D,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid_F,
    output logic [31:0] instr_F,
    output logic [31:0] pc,
    output logic [31:0] pcplus4_F
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    typedef enum logic {WAKE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [31:0]   fpc;
    logic [31:0]   stale_pc;       // redirect target parked while a stale request is still unaccepted
    logic          stale;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;

    // issued-address queue: one entry per in-flight request, in issue order
    logic [31:0]   aq_mem [DEPTH];
    logic [AW-1:0] aq_wr;
    logic [AW-1:0] aq_rd;

    // prefetch FIFO: {address, instruction} pairs awaiting decode
    logic [31:0]   df_addr [DEPTH];
    logic [31:0]   df_data [DEPTH];
    logic [AW-1:0] df_wr;
    logic [AW-1:0] df_rd;

    logic [OW-1:0] occupancy;
    logic          accept;
    logic          pending;
    logic          push;
    logic          pop;
    logic [CW-1:0] inflight_nxt;

    // Credits: every issued request owns a FIFO slot until it is consumed or dropped,
    // so the FIFO can never overflow. While a request waits for ready, occupancy cannot
    // grow (only an accept raises it), which keeps valid and addr stable until acceptance.
    assign occupancy      = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid = (state == RUN) && (occupancy < OW'(DEPTH));
    assign imem_req_addr  = fpc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign pending        = imem_req_valid & ~imem_req_ready;
    assign inflight_nxt   = inflight + CW'(accept) - CW'(imem_rsp_valid);

    // A response arriving with a redirect belongs to the old stream and is discarded.
    assign push = imem_rsp_valid && (drop == '0) && !redirect;
    assign pop  = instr_valid_F && !stall_D && !redirect;

    assign instr_valid_F = (count != '0);
    assign instr_F       = instr_valid_F ? df_data[df_rd] : 32'h0;
    assign pc            = instr_valid_F ? df_addr[df_rd] : fpc;
    assign pcplus4_F     = pc + 32'd4;

    // Fetch FSM, fetch PC, stale-request tracking and drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WAKE;
            fpc      <= RESET_PC;
            stale    <= 1'b0;
            stale_pc <= RESET_PC;
            drop     <= '0;
        end else begin
            case (state)
                WAKE:    state <= RUN;
                default: state <= RUN;
            endcase
            if (redirect) begin
                if (pending) begin
                    // the held request must still go out; steer fpc once it is accepted
                    stale    <= 1'b1;
                    stale_pc <= redirect_pc;
                end else begin
                    stale <= 1'b0;
                    fpc   <= redirect_pc;
                end
                // everything still outstanding, plus the held request, is old-stream
                drop <= inflight_nxt + CW'(pending);
            end else begin
                if (accept) begin
                    if (stale) begin
                        fpc   <= stale_pc;
                        stale <= 1'b0;
                    end else begin
                        fpc <= fpc + 32'd4;
                    end
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Issued-address queue pointers and in-flight count; not flushed by redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aq_wr    <= '0;
            aq_rd    <= '0;
            inflight <= '0;
        end else begin
            if (accept) begin
                aq_wr <= aq_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
                aq_rd <= aq_rd + AW'(1);
            end
            inflight <= inflight_nxt;
        end
    end

    // Prefetch FIFO pointers and occupancy; redirect empties it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            df_wr <= '0;
            df_rd <= '0;
            count <= '0;
        end else if (redirect) begin
            df_wr <= '0;
            df_rd <= '0;
            count <= '0;
        end else begin
            if (push) begin
                df_wr <= df_wr + AW'(1);
            end
            if (pop) begin
                df_rd <= df_rd + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Queue storage; contents are only observed behind valid pointers, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            aq_mem[aq_wr] <= fpc;
        end
        if (push) begin
            df_addr[df_wr] <= aq_mem[aq_rd];
            df_data[df_wr] <= imem_rsp_data;
        end
    end

    // A response with nothing outstanding means the memory side is broken
    always_ff @(posedge clk) begin
        if (reset && imem_rsp_valid) begin
            assert (inflight != '0);
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
`timescale 1ns/1ps
module tb_ifetch_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_D;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid_F;
    logic [31:0] instr_F;
    logic [31:0] pc;
    logic [31:0] pcplus4_F;

    always #5 clk = ~clk;

    ifetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_D        (stall_D),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid_F  (instr_valid_F),
        .instr_F        (instr_F),
        .pc             (pc),
        .pcplus4_F      (pcplus4_F)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat_min;
    int lat_max;

    // memory model: accepted requests with the cycle their response becomes visible
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];

    // consumer-side model: the address the next instruction at the head must carry
    logic [31:0] exp_pc;
    logic        prev_pending;
    logic [31:0] prev_addr;
    logic        ok;
    logic [31:0] r;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // one clock: check outputs at the falling edge, update models at the rising edge,
    // then drive the memory response for the new cycle
    task automatic tick();
        logic        s_rv;
        logic        s_iv;
        logic        s_stall;
        logic        s_redir;
        logic        s_rsp;
        logic        s_acc;
        logic [31:0] s_ra;
        logic [31:0] s_rpc;
        int          lat;
        int          due;
        @(negedge clk);
        s_rv    = imem_req_valid;
        s_ra    = imem_req_addr;
        s_iv    = instr_valid_F;
        s_stall = stall_D;
        s_redir = redirect;
        s_rpc   = redirect_pc;
        s_rsp   = imem_rsp_valid;
        check("pcplus4", pcplus4_F, pc + 32'd4);
        if (s_iv) begin
            check("instr_word", instr_F, mem_word(pc));
            check("pc_order", pc, exp_pc);
        end else begin
            check("instr_nop", instr_F, 32'h0);
        end
        if (prev_pending) begin
            check("hold_valid", 32'(s_rv), 32'h1);
            check("hold_addr", s_ra, prev_addr);
        end
        s_acc = s_rv & imem_req_ready;
        if (s_acc) begin
            check("credit", 32'(mem_q.size() < DEPTH), 32'h1);
            check("align", 32'(s_ra[1:0]), 32'h0);
        end
        prev_pending = s_rv & ~imem_req_ready;
        prev_addr    = s_ra;
        @(posedge clk);
        cyc++;
        if (reset) begin
            if (s_rsp) mem_q.delete(0);
            if (s_acc) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat - 1;
                if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
                mem_q.push_back('{addr: s_ra, due: due});
            end
            if (s_iv && !s_stall && !s_redir) exp_pc = exp_pc + 32'd4;
            if (s_redir) exp_pc = s_rpc;
        end
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_valid_F && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(instr_valid_F), 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        check({tag, "_instr_valid"}, 32'(instr_valid_F), 32'h0);
        check({tag, "_instr"}, instr_F, 32'h0);
        check({tag, "_pc"}, pc, RESET_PC);
        check({tag, "_pcplus4"}, pcplus4_F, RESET_PC + 32'd4);
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall_D        = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        exp_pc         = RESET_PC;
        prev_pending   = 1'b0;
        prev_addr      = 32'h0;
        lat_min        = 1;
        lat_max        = 1;
        ok             = 1'b0;
        r              = 32'h0;

        #2;
        check_reset_outputs("rst");
        tick();
        tick();
        reset = 1'b1;

        // 1: wake cycle, first request, first-instruction latency, 1/cycle throughput
        check("t1_wake_idle", 32'(imem_req_valid), 32'h0);
        tick();
        check("t1_req0_valid", 32'(imem_req_valid), 32'h1);
        check("t1_req0_addr", imem_req_addr, RESET_PC);
        check("t1_c1_empty", 32'(instr_valid_F), 32'h0);
        tick();
        check("t1_c2_empty", 32'(instr_valid_F), 32'h0);
        check("t1_req1_addr", imem_req_addr, RESET_PC + 32'd4);
        tick();
        check("t1_first_valid", 32'(instr_valid_F), 32'h1);
        check("t1_first_pc", pc, RESET_PC);
        tick();
        check("t1_second_valid", 32'(instr_valid_F), 32'h1);
        check("t1_second_pc", pc, RESET_PC + 32'd4);
        repeat (6) tick();

        // 2: decode stall fills the FIFO and throttles issue
        stall_D = 1'b1;
        repeat (5) tick();
        check("t2_req_throttled", 32'(imem_req_valid), 32'h0);
        check("t2_head_valid", 32'(instr_valid_F), 32'h1);
        check("t2_head_pc", pc, exp_pc);
        stall_D = 1'b0;
        repeat (8) tick();

        // 3: redirect with three requests in flight
        lat_min = 5;
        lat_max = 5;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (mem_q.size() == 3) ok = 1'b1;
        end
        check("t3_three_inflight", 32'(ok), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        wait_valid("t3_wait", 40);
        check("t3_pc", pc, 32'h100);
        check("t3_pcplus4", pcplus4_F, 32'h104);

        // 4: redirect while the request at 0x20 is held by ready = 0
        lat_min     = 1;
        lat_max     = 1;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (imem_req_valid && imem_req_addr == 32'h20) ok = 1'b1;
            else tick();
        end
        check("t4_reach_0x20", 32'(ok), 32'h1);
        imem_req_ready = 1'b0;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check("t4_valid_held", 32'(imem_req_valid), 32'h1);
        check("t4_addr_held", imem_req_addr, 32'h20);
        imem_req_ready = 1'b1;
        tick();
        check("t4_resume_valid", 32'(imem_req_valid), 32'h1);
        check("t4_resume_addr", imem_req_addr, 32'h200);
        wait_valid("t4_wait", 40);
        check("t4_pc", pc, 32'h200);

        // 5: redirect coinciding with a response and a pop
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (instr_valid_F && imem_rsp_valid && !stall_D) ok = 1'b1;
            else tick();
        end
        check("t5_sync_point", 32'(ok), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        check("t5_flushed", 32'(instr_valid_F), 32'h0);
        wait_valid("t5_wait", 40);
        check("t5_pc", pc, 32'h300);

        // 6: asynchronous reset mid-stream with two responses outstanding
        lat_min = 3;
        lat_max = 3;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (mem_q.size() == 2) ok = 1'b1;
        end
        check("t6_two_pending", 32'(ok), 32'h1);
        #2;
        reset = 1'b0;
        mem_q.delete();
        prev_pending   = 1'b0;
        imem_rsp_valid = 1'b0;
        exp_pc         = RESET_PC;
        #1;
        check_reset_outputs("t6");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_restart_valid", 32'(imem_req_valid), 32'h1);
        check("t6_restart_addr", imem_req_addr, RESET_PC);
        wait_valid("t6_wait", 20);
        check("t6_pc", pc, RESET_PC);

        // randomized traffic: ready, stall, latency and redirects
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            stall_D        = ($urandom_range(0, 3) == 0);
            redirect       = ($urandom_range(0, 24) == 0);
            r              = $urandom();
            redirect_pc    = {r[31:2], 2'b00};
            tick();
        end
        redirect       = 1'b0;
        stall_D        = 1'b0;
        imem_req_ready = 1'b1;
        wait_valid("final_wait", 40);
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
